gsim_sched: RTL and testbench
=============================

GSIM_SCHED -- requirements
Module: gsim_sched

Interface
REQ-001 Parameter NUM_VAR, default 16: b-values per problem frame and x-values per result frame.
REQ-002 Parameter TIMEOUT_CYC, default 8191: watchdog limit in cycles, used only when GSIM_SCHED_WATCHDOG_EN is defined.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester n presents a b-value.
REQ-006 req0_b / req1_b  input  16 (signed) each  b-value from requester n.
REQ-007 req0_ready / req1_ready  output  1 each  scheduler accepts requester n's beat this cycle.
REQ-008 core_in_en  output  1  load strobe to the solver core.
REQ-009 core_b_in  output  16 (signed)  b-value to the solver core.
REQ-010 core_out_valid  input  1  solver core result beat valid.
REQ-011 core_x_out  input  32  solver core result value.
REQ-012 core_reset  output  1  active-high reset pulse to the solver core.
REQ-013 res_valid  output  1  result beat valid.
REQ-014 res_id  output  1  owner of the result beat: 0 or 1.
REQ-015 res_idx  output  4  index of the x-value within the frame, 0..NUM_VAR-1.
REQ-016 res_x  output  32  result value.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 err  output  1  sticky error flag.

Function
REQ-019 The state machine SHALL have exactly four states: IDLE, LOAD, WAIT, DRAIN.
REQ-020 IDLE, arbitration:
- if any reqN_valid is high, the grant is registered and the next state is LOAD;
- if both are high, the requester other than the last-served one wins;
- after reset, requester 0 has priority.
REQ-021 LOAD, handshake:
- only the granted requester's ready is high; the other ready is 0;
- a beat is accepted when valid and ready are both high;
- on an accepted beat, core_in_en=1 and core_b_in=the granted requester's b in the same cycle (combinational path);
- gaps in valid are allowed and produce core_in_en=0.
REQ-022 LOAD, completion: beat counter increments per accepted beat; on the NUM_VAR-th beat, the next state is WAIT and the counter clears.
REQ-023 WAIT: core_out_valid=1 moves to DRAIN and forwards that beat as index 0.
REQ-024 WAIT/DRAIN, result forwarding (combinational):
- res_valid=core_out_valid;
- res_x=core_x_out;
- res_id=the granted requester;
- res_idx=the result counter.
REQ-025 DRAIN: on the NUM_VAR-th result beat, the next state is IDLE, last-served is set to the granted requester, and counters clear.
REQ-026 Results have no backpressure; every core_out_valid beat in WAIT/DRAIN is forwarded.
REQ-027 core_out_valid high in IDLE or LOAD SHALL set err, and the beat is not forwarded.
REQ-028 DRAIN seeing core_out_valid=0 before NUM_VAR beats SHALL set err and remain in DRAIN.
REQ-029 A requester valid that arrives during the final DRAIN cycle is arbitrated in the following IDLE cycle (IDLE occupies at least one cycle).
REQ-030 Unused outputs are 0: core_b_in=0 when core_in_en=0; res_x and res_idx are 0 when res_valid=0.

Reset
REQ-031 Reset SHALL asynchronously force:
- state IDLE;
- all counters 0;
- grant 0 and last-served 1 (so requester 0 has priority);
- err 0.
REQ-032 During and after reset, every output SHALL be 0 until driven by the state machine.
REQ-033 Reset mid-frame SHALL abandon the frame with no result emitted; the core is not reset by the scheduler in this case.

Configuration
REQ-034 With GSIM_SCHED_WATCHDOG_EN defined:
- a cycle counter runs in WAIT;
- on reaching TIMEOUT_CYC with no core_out_valid, core_reset pulses high for exactly 1 cycle, err is set, and the next state is IDLE with last-served updated.
REQ-035 With GSIM_SCHED_WATCHDOG_EN undefined: WAIT waits indefinitely, core_reset is tied 0, and no watchdog counter exists.

Verification
REQ-036 Single frame: req0 sends b=1..16 back-to-back.
- 16 core_in_en beats with matching core_b_in;
- the core's 16 results appear as res_valid with res_id=0, res_idx=0..15;
- busy returns 0.
REQ-037 Contention: both valid from reset.
- req0 is served first, then req1;
- on the next simultaneous request, req0 is served.
REQ-038 Gapped load: req1_valid toggles every other cycle.
- exactly 16 core_in_en pulses;
- req0_ready stays 0 throughout.
REQ-039 Spurious core_out_valid in IDLE: err=1, res_valid stays 0, and err remains 1 until reset.
REQ-040 With GSIM_SCHED_WATCHDOG_EN and TIMEOUT_CYC=100, core silent after load: core_reset is high exactly 1 cycle, 100 cycles into WAIT, err=1, state IDLE.
REQ-041 Reset asserted at load beat 7: all outputs 0 immediately; a new frame then loads 16 fresh beats correctly.

Source files
------------

// File: rtl/gsim_sched.sv
// gsim_sched: two-requester frame scheduler in front of an iterative solver core.
// Define GSIM_SCHED_WATCHDOG_EN to build in the WAIT-state core watchdog.
module gsim_sched #(
    parameter int NUM_VAR     = 16,
    parameter int TIMEOUT_CYC = 8191,
    parameter int DATA_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic signed [DATA_W-1:0] req0_b,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic signed [DATA_W-1:0] req1_b,
    output logic                     req1_ready,
    output logic                     core_in_en,
    output logic signed [DATA_W-1:0] core_b_in,
    input  logic                     core_out_valid,
    input  logic [31:0]              core_x_out,
    output logic                     core_reset,
    output logic                     res_valid,
    output logic                     res_id,
    output logic [3:0]               res_idx,
    output logic [31:0]              res_x,
    output logic                     busy,
    output logic                     err
);

    if (NUM_VAR < 1 || NUM_VAR > 16) begin : g_bad_num_var
        $error("NUM_VAR must be in 1..16");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be positive");
    end

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_VAR - 1);

    state_t     state, state_nxt;
    logic       grant, grant_nxt, last_served;
    logic [3:0] beat_cnt, res_cnt;
    logic       err_r;
    logic       accept, fwd, frame_done, timeout, spurious;

    assign accept     = (state == LOAD) && (grant ? req1_valid : req0_valid);
    assign fwd        = ((state == WAIT) || (state == DRAIN)) && core_out_valid;
    assign frame_done = fwd && (res_cnt == LAST_IDX);
    assign spurious   = core_out_valid && ((state == IDLE) || (state == LOAD));
    // Round-robin: on contention the requester not served last wins.
    assign grant_nxt  = (req0_valid && req1_valid) ? ~last_served : req1_valid;

`ifdef GSIM_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    assign timeout = (state == WAIT) && !core_out_valid &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wd_cnt <= '0;
        else if ((state == WAIT) && (state_nxt == WAIT))
            wd_cnt <= wd_cnt + 1'b1;
        else
            wd_cnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_served <= 1'b1;
            beat_cnt    <= '0;
            res_cnt     <= '0;
            err_r       <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && (state_nxt == LOAD))
                grant <= grant_nxt;
            if (accept)
                beat_cnt <= (beat_cnt == LAST_IDX) ? 4'd0 : beat_cnt + 4'd1;
            if (frame_done)
                res_cnt <= '0;
            else if (fwd)
                res_cnt <= res_cnt + 4'd1;
            if (frame_done || timeout)
                last_served <= grant;
            // Sticky: results outside WAIT/DRAIN, a stalled drain, or a core timeout.
            if (spurious || ((state == DRAIN) && !core_out_valid) || timeout)
                err_r <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0_valid || req1_valid) state_nxt = LOAD;
            LOAD:    if (accept && (beat_cnt == LAST_IDX)) state_nxt = WAIT;
            WAIT: begin
                if (frame_done)   state_nxt = IDLE;
                else if (fwd)     state_nxt = DRAIN;
                else if (timeout) state_nxt = IDLE;
            end
            DRAIN:   if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == LOAD) && !grant;
        req1_ready = (state == LOAD) && grant;
        core_in_en = accept;
        core_b_in  = '0;
        if (accept)
            core_b_in = grant ? req1_b : req0_b;
        res_valid  = fwd;
        res_id     = ((state == WAIT) || (state == DRAIN)) && grant;
        res_idx    = fwd ? res_cnt : 4'd0;
        res_x      = fwd ? core_x_out : 32'd0;
        busy       = (state != IDLE);
        core_reset = timeout;
        err        = err_r;
    end

endmodule

// File: tb/tb_gsim_sched.sv
// Directed bench for gsim_sched: frame table plus hand sequences for reset,
// error and watchdog corner cases.
module tb_gsim_sched;

    localparam int NV = 16;
`ifdef GSIM_SCHED_WATCHDOG_EN
    localparam int TO = 100;
`else
    localparam int TO = 8191;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               req0_valid, req1_valid;
    logic signed [15:0] req0_b, req1_b;
    logic               req0_ready, req1_ready;
    logic               core_in_en;
    logic signed [15:0] core_b_in;
    logic               core_out_valid;
    logic [31:0]        core_x_out;
    logic               core_reset;
    logic               res_valid, res_id;
    logic [3:0]         res_idx;
    logic [31:0]        res_x;
    logic               busy, err;

    int  checks = 0;
    int  errors = 0;
    bit  exp_err = 1'b0;

    gsim_sched #(.NUM_VAR(NV), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_b(req1_b), .req1_ready(req1_ready),
        .core_in_en(core_in_en), .core_b_in(core_b_in),
        .core_out_valid(core_out_valid), .core_x_out(core_x_out),
        .core_reset(core_reset),
        .res_valid(res_valid), .res_id(res_id), .res_idx(res_idx), .res_x(res_x),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                 r0v;
        bit                 r1v;
        bit                 gap;
        logic signed [15:0] base;
        bit                 exp_id;
    } frame_t;

    frame_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one load phase for requester g; the other requester holds other_v.
    task automatic do_load(input bit g, input bit gap, input logic signed [15:0] base,
                           input bit other_v, input int nbeats);
        int beats = 0;
        int n = 0;
        int pulses = 0;
        logic v;
        logic signed [15:0] b;
        while (beats < nbeats && n < 200) begin
            v = gap ? ((n % 2) == 0) : 1'b1;
            b = base + 16'(beats);
            if (g) begin
                req1_valid = v; req1_b = b; req0_valid = other_v; req0_b = 16'sh7ABC;
            end else begin
                req0_valid = v; req0_b = b; req1_valid = other_v; req1_b = 16'sh7ABC;
            end
            #2;
            chk("ready_granted", g ? req1_ready : req0_ready, 1);
            chk("ready_other", g ? req0_ready : req1_ready, 0);
            chk("core_in_en", core_in_en, v);
            chk("core_b_in", core_b_in, v ? b : 16'sh0000);
            if (core_in_en) pulses++;
            if (v) beats++;
            n++;
            cyc();
        end
        chk("load_beats", beats, nbeats);
        chk("in_en_pulses", pulses, nbeats);
        if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic do_drain(input bit g, input logic signed [15:0] base,
                            input int gap_at, input bit last_req0);
        logic [31:0] x;
        for (int w = 0; w < 2; w++) begin
            core_out_valid = 1'b0;
            #2;
            chk("wait_busy", busy, 1);
            chk("wait_res_valid", res_valid, 0);
            cyc();
        end
        for (int i = 0; i < NV; i++) begin
            if (i == gap_at) begin
                core_out_valid = 1'b0;
                #2;
                chk("gap_busy", busy, 1);
                chk("gap_res_valid", res_valid, 0);
                cyc();
                chk("gap_err", err, 1);
            end
            x = {base, 12'hA50, 4'(i)};
            core_out_valid = 1'b1;
            core_x_out = x;
            if (last_req0 && i == NV - 1) begin
                req0_valid = 1'b1; req0_b = 16'sh0042;
            end
            #2;
            chk("res_valid", res_valid, 1);
            chk("res_id", res_id, g);
            chk("res_idx", res_idx, i);
            chk("res_x", res_x, x);
            cyc();
        end
        core_out_valid = 1'b0;
        core_x_out = '0;
    endtask

    task automatic run_frame(input bit r0v, input bit r1v, input bit gap,
                             input logic signed [15:0] base, input bit exp_id);
        req0_valid = r0v; req1_valid = r1v;
        req0_b = 16'sh1234; req1_b = 16'sh5678;
        #2;
        chk("idle_busy", busy, 0);
        chk("idle_ready0", req0_ready, 0);
        chk("idle_ready1", req1_ready, 0);
        chk("idle_in_en", core_in_en, 0);
        chk("idle_b", core_b_in, 0);
        cyc();
        do_load(exp_id, gap, base, exp_id ? r0v : r1v, NV);
        req0_valid = 1'b0; req1_valid = 1'b0;
        do_drain(exp_id, base, -1, 1'b0);
        #2;
        chk("end_busy", busy, 0);
        chk("end_err", err, exp_err);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
        chk({tag, "_in_en"}, core_in_en, 0);
        chk({tag, "_b"}, core_b_in, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_x"}, res_x, 0);
        chk({tag, "_res_idx"}, res_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_core_reset"}, core_reset, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, want finished at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int hi;
        int first;

        tbl[0] = '{1'b1, 1'b0, 1'b0,  16'sd1,     1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0,  16'sd100,   1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, -16'sd8,     1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1,  16'sd200,   1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, -16'sd300,   1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b0,  16'sd7,     1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b1,  16'sd50,    1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0,  16'sh7FF0,  1'b1};
        tbl[8] = '{1'b1, 1'b1, 1'b0,  16'sh8000,  1'b0};

        // Reset with live inputs: outputs must stay quiet.
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_b = 16'sh1111; req1_b = 16'sh2222;
        core_out_valid = 1'b1; core_x_out = 32'hDEAD_BEEF;
        #2;
        check_all_zero("rst");
        cyc(); cyc();
        check_all_zero("rst2");
        req0_valid = 1'b0; req1_valid = 1'b0; core_out_valid = 1'b0; core_x_out = '0;
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_frame(tbl[i].r0v, tbl[i].r1v, tbl[i].gap, tbl[i].base, tbl[i].exp_id);

        // Contention straight out of reset: 0, then 1, then 0 again.
        reset = 1'b1; cyc(); reset = 1'b0;
        run_frame(1'b1, 1'b1, 1'b0, 16'sd1000, 1'b0);
        run_frame(1'b1, 1'b1, 1'b0, 16'sd2000, 1'b1);
        run_frame(1'b1, 1'b1, 1'b0, 16'sd3000, 1'b0);

        // Request raised during the final drain beat waits for one IDLE cycle.
        req1_valid = 1'b1; cyc();
        do_load(1'b1, 1'b0, 16'sd60, 1'b0, NV);
        do_drain(1'b1, 16'sd60, -1, 1'b1);
        #2;
        chk("late_req_idle_busy", busy, 0);
        chk("late_req_idle_ready0", req0_ready, 0);
        cyc();
        do_load(1'b0, 1'b0, 16'sd70, 1'b0, NV);
        do_drain(1'b0, 16'sd70, -1, 1'b0);
        #2;
        chk("late_req_end_busy", busy, 0);

        // Spurious core result in IDLE.
        core_out_valid = 1'b1; core_x_out = 32'h0000_0123;
        #2;
        chk("spur_res_valid", res_valid, 0);
        chk("spur_res_x", res_x, 0);
        chk("spur_res_idx", res_idx, 0);
        cyc();
        core_out_valid = 1'b0; core_x_out = '0;
        #2;
        chk("spur_err", err, 1);
        exp_err = 1'b1;
        run_frame(1'b0, 1'b1, 1'b0, 16'sd80, 1'b1);
        reset = 1'b1; #1;
        chk("spur_err_cleared", err, 0);
        cyc(); reset = 1'b0; exp_err = 1'b0;

        // Drain stall: err set, frame still completes.
        req1_valid = 1'b1; cyc();
        do_load(1'b1, 1'b0, 16'sd90, 1'b0, NV);
        do_drain(1'b1, 16'sd90, 5, 1'b0);
        #2;
        chk("stall_end_busy", busy, 0);
        chk("stall_end_err", err, 1);

        // Reset at load beat 7 abandons the frame.
        reset = 1'b1; cyc(); reset = 1'b0;
        req0_valid = 1'b1; cyc();
        do_load(1'b0, 1'b0, 16'sd10, 1'b0, 7);
        req0_valid = 1'b1; req0_b = 16'sd17;
        #1;
        chk("pre_rst_in_en", core_in_en, 1);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        cyc();
        reset = 1'b0; req0_valid = 1'b0;
        run_frame(1'b1, 1'b0, 1'b0, 16'sd500, 1'b0);

`ifdef GSIM_SCHED_WATCHDOG_EN
        req1_valid = 1'b1; cyc();
        do_load(1'b1, 1'b0, 16'sd900, 1'b0, NV);
        hi = 0; first = 0;
        for (int n = 1; n <= TO + 5; n++) begin
            #2;
            if (core_reset) begin
                hi++;
                if (first == 0) first = n;
            end
            cyc();
        end
        chk("wd_pulses", hi, 1);
        chk("wd_cycle", first, TO);
        chk("wd_err", err, 1);
        chk("wd_busy", busy, 0);
        exp_err = 1'b1;
        run_frame(1'b1, 1'b1, 1'b0, 16'sd40, 1'b0);
`else
        req0_valid = 1'b1; cyc();
        do_load(1'b0, 1'b0, 16'sd900, 1'b0, NV);
        hi = 0; first = 0;
        for (int n = 1; n <= 300; n++) begin
            #2;
            if (core_reset) hi++;
            cyc();
        end
        chk("nowd_pulses", hi, 0);
        chk("nowd_busy", busy, 1);
        chk("nowd_err", err, 0);
        do_drain(1'b0, 16'sd900, -1, 1'b0);
        #2;
        chk("nowd_end_busy", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
